// File: rtl/cpu_id_pkg.sv
// Shared types for the ID stage: widths, decoded-control bundle, ID/EX register layout
// and the write-port bypass selector.
package cpu_id_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int AW     = $clog2(NREG);
    localparam int MAX_WB = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLL = 3'd4
    } alu_op_t;

    // rd1_rt steers read port 1 to the rt field (shift-by-immediate reads rt only)
    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        alu_op_t alu_op;
        logic    rd1_rt;
        logic    rd2_en;
        logic    rd1_en;
    } con_t;

    localparam int   CON_W   = $bits(con_t);
    localparam con_t CON_NOP = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
        con_t            controls;
        logic [AW-1:0]   rd1_num;
        logic [XLEN-1:0] rd1_data;
        logic [AW-1:0]   rd2_num;
        logic [XLEN-1:0] rd2_data;
    } idex_t;

    // Highest-numbered hitting write port, or -1 when none hits.
    function automatic int bypass_sel(input logic [MAX_WB-1:0] hits);
        int sel;
        sel = -1;
        for (int i = 0; i < MAX_WB; i++) begin
            if (hits[i]) sel = i;
        end
        return sel;
    endfunction

endpackage

// File: rtl/cpu_control.sv
// Instruction decoder: opcode/funct to the control bundle; unknown encodings decode as NOP.
module cpu_control
    import cpu_id_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output con_t       controls
);

    always_comb begin
        controls = CON_NOP;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00: begin
                        controls.rd1_en    = 1'b1;
                        controls.rd1_rt    = 1'b1;
                        controls.reg_write = 1'b1;
                        controls.alu_op    = ALU_SLL;
                    end
                    6'h20, 6'h22, 6'h24, 6'h25: begin
                        controls.rd1_en    = 1'b1;
                        controls.rd2_en    = 1'b1;
                        controls.reg_write = 1'b1;
                        case (funct)
                            6'h22:   controls.alu_op = ALU_SUB;
                            6'h24:   controls.alu_op = ALU_AND;
                            6'h25:   controls.alu_op = ALU_OR;
                            default: controls.alu_op = ALU_ADD;
                        endcase
                    end
                    default: ;
                endcase
            end
            6'h23: begin
                controls.rd1_en    = 1'b1;
                controls.reg_write = 1'b1;
                controls.mem_read  = 1'b1;
            end
            6'h2B: begin
                controls.rd1_en    = 1'b1;
                controls.rd2_en    = 1'b1;
                controls.mem_write = 1'b1;
            end
            6'h08: begin
                controls.rd1_en    = 1'b1;
                controls.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-write-port register file, two async read ports with write-first bypass; reg 0 is hardwired 0.
module regfile_mp #(
    parameter  int NREG   = 32,
    parameter  int XLEN   = 32,
    parameter  int NUM_WB = 2,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic [NUM_WB-1:0]      wb_en,
    input  logic [NUM_WB*AW-1:0]   wb_num,
    input  logic [NUM_WB*XLEN-1:0] wb_data,
    input  logic [AW-1:0]          rd1_num,
    input  logic [AW-1:0]          rd2_num,
    output logic [XLEN-1:0]        rd1_data,
    output logic [XLEN-1:0]        rd2_data
);

    logic [XLEN-1:0]               regs [NREG];
    logic [AW-1:0]                 rnum [2];
    logic [XLEN-1:0]               rdat [2];
    logic [cpu_id_pkg::MAX_WB-1:0] hits [2];
    int                            sel  [2];

    // Later ports are assigned last, so the highest port wins a same-register collision.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_en[i] && wb_num[i*AW +: AW] != '0)
                    regs[wb_num[i*AW +: AW]] <= wb_data[i*XLEN +: XLEN];
            end
        end
    end

    assign rnum[0] = rd1_num;
    assign rnum[1] = rd2_num;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hits[p] = '0;
            for (int i = 0; i < NUM_WB; i++)
                hits[p][i] = wb_en[i] && (wb_num[i*AW +: AW] == rnum[p]);
            sel[p] = cpu_id_pkg::bypass_sel(hits[p]);
            if (rnum[p] == '0)
                rdat[p] = '0;
            else if (sel[p] >= 0)
                rdat[p] = wb_data[sel[p]*XLEN +: XLEN];
            else
                rdat[p] = regs[rnum[p]];
        end
    end

    assign rd1_data = rdat[0];
    assign rd2_data = rdat[1];

endmodule

// File: rtl/cpu_id_stage_hs.sv
// Decode/register-read stage with valid/ready ID/EX register, load-use interlock
// and writeback refresh of operands held under backpressure.
module cpu_id_stage_hs
    import cpu_id_pkg::*;
#(
    parameter int NUM_WB = 2
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        pc_in,
    input  logic [XLEN-1:0]        ins,
    input  logic                   flush,
    input  logic                   ex_load,
    input  logic [AW-1:0]          ex_rd,
    input  logic [NUM_WB-1:0]      wb_en,
    input  logic [NUM_WB*AW-1:0]   wb_num,
    input  logic [NUM_WB*XLEN-1:0] wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        pc_id,
    output logic [XLEN-1:0]        ins_id,
    output logic [CON_W-1:0]       controls,
    output logic [XLEN-1:0]        rd1_data,
    output logic [XLEN-1:0]        rd2_data,
    output logic [AW-1:0]          rd1_num,
    output logic [AW-1:0]          rd2_num,
    output logic [AW-1:0]          rd1_num_rt,
    output logic [AW-1:0]          rd2_num_rt
);

    con_t            dec;
    idex_t           idex;
    logic            valid_q;
    logic [XLEN-1:0] rf_rd1, rf_rd2, held1, held2;
    logic            hazard, advance;

    cpu_control u_control (
        .op       (ins[31:26]),
        .funct    (ins[5:0]),
        .controls (dec)
    );

    assign rd1_num_rt = !dec.rd1_en ? '0 : (dec.rd1_rt ? ins[16 +: AW] : ins[21 +: AW]);
    assign rd2_num_rt = dec.rd2_en ? ins[16 +: AW] : '0;

    regfile_mp #(.NREG(NREG), .XLEN(XLEN), .NUM_WB(NUM_WB)) u_regfile (
        .clk      (clk),
        .clr_n    (clr_n),
        .wb_en    (wb_en),
        .wb_num   (wb_num),
        .wb_data  (wb_data),
        .rd1_num  (rd1_num_rt),
        .rd2_num  (rd2_num_rt),
        .rd1_data (rf_rd1),
        .rd2_data (rf_rd2)
    );

    assign hazard   = in_valid && ex_load && (ex_rd != '0) &&
                      ((ex_rd == rd1_num_rt) || (ex_rd == rd2_num_rt));
    assign advance  = !valid_q || out_ready;
    assign in_ready = advance && !hazard && !flush;

    // A held operand picks up any writeback to its register so it is current on release.
    always_comb begin
        held1 = idex.rd1_data;
        held2 = idex.rd2_data;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_en[i] && idex.rd1_num != '0 && wb_num[i*AW +: AW] == idex.rd1_num)
                held1 = wb_data[i*XLEN +: XLEN];
            if (wb_en[i] && idex.rd2_num != '0 && wb_num[i*AW +: AW] == idex.rd2_num)
                held2 = wb_data[i*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            valid_q <= 1'b0;
            idex    <= '0;
        end else if (flush) begin
            valid_q       <= 1'b0;
            idex.controls <= CON_NOP;
            idex.ins      <= '0;
        end else if (advance) begin
            valid_q      <= in_valid && !hazard;
            idex.pc      <= pc_in;
            idex.rd1_num <= rd1_num_rt;
            idex.rd2_num <= rd2_num_rt;
            if (in_valid && !hazard) begin
                idex.ins      <= ins;
                idex.controls <= dec;
                idex.rd1_data <= rf_rd1;
                idex.rd2_data <= rf_rd2;
            end else begin
                idex.ins      <= '0;
                idex.controls <= CON_NOP;
                idex.rd1_data <= '0;
                idex.rd2_data <= '0;
            end
        end else begin
            idex.rd1_data <= held1;
            idex.rd2_data <= held2;
        end
    end

    assign out_valid = valid_q;
    assign pc_id     = idex.pc;
    assign ins_id    = idex.ins;
    assign controls  = idex.controls;
    assign rd1_data  = idex.rd1_data;
    assign rd2_data  = idex.rd2_data;
    assign rd1_num   = idex.rd1_num;
    assign rd2_num   = idex.rd2_num;

endmodule

// File: tb/tb_cpu_id_stage_hs.sv
// Bench for cpu_id_stage_hs: decode table, directed multi-cycle corner cases,
// then randomized traffic against a behavioural model of the stage.
module tb_cpu_id_stage_hs;
    import cpu_id_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n, in_valid, in_ready, flush, ex_load, out_valid, out_ready;
    logic [31:0] pc_in, ins, pc_id, ins_id, rd1_data, rd2_data;
    logic [4:0]  ex_rd, rd1_num, rd2_num, rd1_num_rt, rd2_num_rt;
    logic [1:0]  wb_en;
    logic [9:0]  wb_num;
    logic [63:0] wb_data;
    logic [CON_W-1:0] controls;

    always #5 clk = ~clk;

    cpu_id_stage_hs #(.NUM_WB(2)) dut (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .ins(ins), .flush(flush), .ex_load(ex_load), .ex_rd(ex_rd),
        .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .pc_id(pc_id), .ins_id(ins_id),
        .controls(controls), .rd1_data(rd1_data), .rd2_data(rd2_data),
        .rd1_num(rd1_num), .rd2_num(rd2_num), .rd1_num_rt(rd1_num_rt), .rd2_num_rt(rd2_num_rt)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_pc, m_ins, m_d1, m_d2;
    con_t        m_con;
    logic [4:0]  m_n1, m_n2;
    logic        last_ready;

    function automatic con_t mk_con(input logic rw, input logic mr, input logic mw,
                                    input alu_op_t alu, input logic r1rt,
                                    input logic r2en, input logic r1en);
        con_t c;
        c.reg_write = rw; c.mem_read = mr; c.mem_write = mw; c.alu_op = alu;
        c.rd1_rt = r1rt; c.rd2_en = r2en; c.rd1_en = r1en;
        return c;
    endfunction

    // Mnemonic-level decode: what each instruction reads and what it does.
    function automatic void exp_dec(input logic [31:0] i, output con_t c,
                                    output logic [4:0] n1, output logic [4:0] n2);
        logic [4:0] rs, rt;
        logic [5:0] op, f;
        rs = i[25:21]; rt = i[20:16]; op = i[31:26]; f = i[5:0];
        c = CON_NOP; n1 = 5'd0; n2 = 5'd0;
        if (op == 6'h00 && f == 6'h20)      begin c = mk_con(1, 0, 0, ALU_ADD, 0, 1, 1); n1 = rs; n2 = rt; end
        else if (op == 6'h00 && f == 6'h22) begin c = mk_con(1, 0, 0, ALU_SUB, 0, 1, 1); n1 = rs; n2 = rt; end
        else if (op == 6'h00 && f == 6'h24) begin c = mk_con(1, 0, 0, ALU_AND, 0, 1, 1); n1 = rs; n2 = rt; end
        else if (op == 6'h00 && f == 6'h25) begin c = mk_con(1, 0, 0, ALU_OR,  0, 1, 1); n1 = rs; n2 = rt; end
        else if (op == 6'h00 && f == 6'h00) begin c = mk_con(1, 0, 0, ALU_SLL, 1, 0, 1); n1 = rt; end
        else if (op == 6'h23)               begin c = mk_con(1, 1, 0, ALU_ADD, 0, 0, 1); n1 = rs; end
        else if (op == 6'h2B)               begin c = mk_con(0, 0, 1, ALU_ADD, 0, 1, 1); n1 = rs; n2 = rt; end
        else if (op == 6'h08)               begin c = mk_con(1, 0, 0, ALU_ADD, 0, 0, 1); n1 = rs; end
    endfunction

    function automatic logic [31:0] wb_over(input logic [4:0] n, input logic [31:0] cur);
        logic [31:0] v;
        v = cur;
        for (int p = 0; p < 2; p++)
            if (n != 0 && wb_en[p] && wb_num[p*5 +: 5] == n) v = wb_data[p*32 +: 32];
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] n);
        return (n == 0) ? 32'd0 : wb_over(n, m_regs[n]);
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
        m_valid = 0; m_pc = 0; m_ins = 0; m_d1 = 0; m_d2 = 0; m_con = CON_NOP; m_n1 = 0; m_n2 = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, "_controls"}, 32'(controls), 32'(m_con));
        chk({tag, "_pc_id"}, pc_id, m_pc);
        chk({tag, "_ins_id"}, ins_id, m_ins);
        chk({tag, "_rd1_data"}, rd1_data, m_d1);
        chk({tag, "_rd2_data"}, rd2_data, m_d2);
        chk({tag, "_rd1_num"}, 32'(rd1_num), 32'(m_n1));
        chk({tag, "_rd2_num"}, 32'(rd2_num), 32'(m_n2));
    endtask

    // Called at posedge+1 with inputs driven; checks combinational outputs before the
    // edge, advances the model across the edge, then checks the ID/EX register.
    task automatic step(input string tag);
        con_t c;
        logic [4:0] n1, n2;
        logic haz, exp_rdy;
        logic [31:0] r1, r2;
        #3;
        exp_dec(ins, c, n1, n2);
        haz = in_valid && ex_load && ex_rd != 0 && (ex_rd == n1 || ex_rd == n2);
        exp_rdy = !flush && (!m_valid || out_ready) && !haz;
        last_ready = in_ready;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
        chk({tag, "_rd1_num_rt"}, 32'(rd1_num_rt), 32'(n1));
        chk({tag, "_rd2_num_rt"}, 32'(rd2_num_rt), 32'(n2));
        r1 = m_read(n1);
        r2 = m_read(n2);
        if (flush) begin
            m_valid = 0; m_con = CON_NOP; m_ins = 0;
        end else if (!m_valid || out_ready) begin
            m_pc = pc_in; m_n1 = n1; m_n2 = n2;
            if (in_valid && !haz) begin
                m_valid = 1; m_ins = ins; m_con = c; m_d1 = r1; m_d2 = r2;
            end else begin
                m_valid = 0; m_ins = 0; m_con = CON_NOP; m_d1 = 0; m_d2 = 0;
            end
        end else begin
            m_d1 = wb_over(m_n1, m_d1);
            m_d2 = wb_over(m_n2, m_d2);
        end
        for (int p = 0; p < 2; p++)
            if (wb_en[p] && wb_num[p*5 +: 5] != 0) m_regs[wb_num[p*5 +: 5]] = wb_data[p*32 +: 32];
        @(posedge clk);
        #1;
        chk_regs(tag);
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; ex_load = 0; ex_rd = 0; out_ready = 1;
        wb_en = 0; wb_num = 0; wb_data = 0; pc_in = 0; ins = 0;
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] f, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, f};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [4:0] rs, rt, rd;
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0: return r_ins(6'h20, rs, rt, rd);
            1: return r_ins(6'h22, rs, rt, rd);
            2: return r_ins(6'h24, rs, rt, rd);
            3: return r_ins(6'h25, rs, rt, rd);
            4: return r_ins(6'h00, rs, rt, rd);
            5: return i_ins(6'h23, rs, rt, 16'($urandom));
            6: return i_ins(6'h2B, rs, rt, 16'($urandom));
            7: return i_ins(6'h08, rs, rt, 16'($urandom));
            8: return i_ins(6'h3F, rs, rt, 16'($urandom));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [31:0] ins;
        con_t        con;
        logic [4:0]  n1;
        logic [4:0]  n2;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] x_sub, x_a, x_b;

        vecs[0] = '{r_ins(6'h20, 5'd1, 5'd2, 5'd3), mk_con(1, 0, 0, ALU_ADD, 0, 1, 1), 5'd1, 5'd2};
        vecs[1] = '{r_ins(6'h22, 5'd5, 5'd6, 5'd4), mk_con(1, 0, 0, ALU_SUB, 0, 1, 1), 5'd5, 5'd6};
        vecs[2] = '{r_ins(6'h24, 5'd1, 5'd3, 5'd7), mk_con(1, 0, 0, ALU_AND, 0, 1, 1), 5'd1, 5'd3};
        vecs[3] = '{r_ins(6'h25, 5'd2, 5'd4, 5'd1), mk_con(1, 0, 0, ALU_OR,  0, 1, 1), 5'd2, 5'd4};
        vecs[4] = '{r_ins(6'h00, 5'd0, 5'd3, 5'd2), mk_con(1, 0, 0, ALU_SLL, 1, 0, 1), 5'd3, 5'd0};
        vecs[5] = '{i_ins(6'h23, 5'd1, 5'd5, 16'd4), mk_con(1, 1, 0, ALU_ADD, 0, 0, 1), 5'd1, 5'd0};
        vecs[6] = '{i_ins(6'h2B, 5'd2, 5'd6, 16'd8), mk_con(0, 0, 1, ALU_ADD, 0, 1, 1), 5'd2, 5'd6};
        vecs[7] = '{i_ins(6'h08, 5'd4, 5'd3, 16'd5), mk_con(1, 0, 0, ALU_ADD, 0, 0, 1), 5'd4, 5'd0};
        vecs[8] = '{i_ins(6'h3F, 5'd1, 5'd2, 16'd0), CON_NOP, 5'd0, 5'd0};
        vecs[9] = '{r_ins(6'h3F, 5'd1, 5'd2, 5'd3), CON_NOP, 5'd0, 5'd0};

        idle();
        clr_n = 0;
        m_reset();
        #2;
        chk_regs("reset");
        @(negedge clk);
        clr_n = 1;
        step("rst_release");

        // decode table
        for (int k = 0; k < 10; k++) begin
            idle();
            in_valid = 1; ins = vecs[k].ins; pc_in = 32'h100 + 32'(k * 4);
            step("dec");
            chk($sformatf("dec%0d_controls", k), 32'(controls), 32'(vecs[k].con));
            chk($sformatf("dec%0d_rd1_num", k), 32'(rd1_num), 32'(vecs[k].n1));
            chk($sformatf("dec%0d_rd2_num", k), 32'(rd2_num), 32'(vecs[k].n2));
        end

        // same-cycle writeback bypass
        idle();
        in_valid = 1; ins = r_ins(6'h20, 5'd8, 5'd8, 5'd9); pc_in = 32'h200;
        wb_en = 2'b01; wb_num = {5'd0, 5'd8}; wb_data = {32'd0, 32'h1234};
        step("bypass");
        chk("bypass_rd1", rd1_data, 32'h1234);
        chk("bypass_rd2", rd2_data, 32'h1234);

        // load-use interlock: one bubble, then the add goes through
        idle();
        in_valid = 1; ins = r_ins(6'h20, 5'd5, 5'd0, 5'd6); pc_in = 32'h204;
        ex_load = 1; ex_rd = 5'd5;
        step("lu_stall");
        chk("lu_stall_ready", 32'(last_ready), 32'd0);
        chk("lu_bubble_valid", 32'(out_valid), 32'd0);
        chk("lu_bubble_con", 32'(controls), 32'(CON_NOP));
        ex_load = 0; ex_rd = 0;
        step("lu_accept");
        chk("lu_accept_ready", 32'(last_ready), 32'd1);
        chk("lu_accept_ins", ins_id, r_ins(6'h20, 5'd5, 5'd0, 5'd6));

        // hold with refresh of operand 2 by a late writeback on port 1
        idle();
        x_sub = r_ins(6'h22, 5'd2, 5'd7, 5'd10);
        in_valid = 1; ins = x_sub; pc_in = 32'h300;
        step("hold_load");
        out_ready = 0; ins = r_ins(6'h20, 5'd1, 5'd1, 5'd1); pc_in = 32'h304;
        step("hold_c1");
        wb_en = 2'b10; wb_num = {5'd7, 5'd0}; wb_data = {32'hCAFE, 32'd0};
        step("hold_c2");
        wb_en = 0; wb_num = 0; wb_data = 0;
        step("hold_c3");
        chk("hold_rd2", rd2_data, 32'hCAFE);
        chk("hold_ins", ins_id, x_sub);
        chk("hold_pc", pc_id, 32'h300);
        chk("hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1;
        step("hold_release");

        // write-port collision and writes to r0
        idle();
        wb_en = 2'b11; wb_num = {5'd3, 5'd3}; wb_data = {32'h2, 32'h1};
        step("coll_wr");
        idle();
        wb_en = 2'b01; wb_num = {5'd0, 5'd0}; wb_data = {32'd0, 32'hFFFF};
        in_valid = 1; ins = r_ins(6'h20, 5'd3, 5'd0, 5'd4); pc_in = 32'h400;
        step("coll_rd");
        chk("coll_r3", rd1_data, 32'h2);
        chk("coll_r0", rd2_data, 32'h0);

        // flush while stalled, then re-acceptance
        idle();
        x_a = r_ins(6'h25, 5'd3, 5'd8, 5'd2);
        x_b = r_ins(6'h24, 5'd9, 5'd3, 5'd1);
        in_valid = 1; ins = x_a; pc_in = 32'h500;
        step("fl_load");
        out_ready = 0; flush = 1; ins = x_b; pc_in = 32'h504;
        step("fl_flush");
        chk("fl_ready", 32'(last_ready), 32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ins", ins_id, 32'd0);
        flush = 0;
        step("fl_reaccept");
        chk("fl_re_ready", 32'(last_ready), 32'd1);
        chk("fl_re_valid", 32'(out_valid), 32'd1);
        chk("fl_re_ins", ins_id, x_b);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            ins       = rand_ins();
            pc_in     = $urandom;
            flush     = ($urandom_range(0, 9) == 0);
            ex_load   = ($urandom_range(0, 2) == 0);
            ex_rd     = 5'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 9) < 7);
            wb_en     = 2'($urandom_range(0, 3));
            wb_num    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wb_data   = {$urandom, $urandom};
            step("rand");
        end

        // reset asserted while holding a valid instruction clears outputs without an edge
        idle();
        in_valid = 1; ins = r_ins(6'h20, 5'd3, 5'd8, 5'd2); pc_in = 32'h600;
        step("rm_load");
        out_ready = 0; in_valid = 0;
        chk("rm_pre_valid", 32'(out_valid), 32'd1);
        #2;
        clr_n = 0;
        #1;
        chk("rm_valid", 32'(out_valid), 32'd0);
        chk("rm_controls", 32'(controls), 32'(CON_NOP));
        chk("rm_rd1", rd1_data, 32'd0);
        chk("rm_rd2", rd2_data, 32'd0);
        chk("rm_ins", ins_id, 32'd0);
        m_reset();
        @(negedge clk);
        clr_n = 1;
        idle();
        in_valid = 1; ins = r_ins(6'h20, 5'd3, 5'd8, 5'd2); pc_in = 32'h700;
        step("rm_after");
        chk("rm_after_rd1", rd1_data, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
